// File: rtl/timestamp_scheduler.sv
// timestamp_scheduler: 10 Hz timestamp counter with round-robin coherent snapshot arbiter (optional OVF via TS_OVERFLOW_FLAG_EN)
module timestamp_scheduler #(
    parameter int TS_WIDTH = 24,
    parameter int NUM_REQ  = 3
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_tick_10hz,
    input  logic                i_load,
    input  logic [TS_WIDTH-1:0] i_load_val,
    input  logic [NUM_REQ-1:0]  i_req,
    output logic [TS_WIDTH-1:0] o_timestamp,
    output logic [TS_WIDTH-1:0] o_snap,
    output logic [NUM_REQ-1:0]  o_gnt,
    output logic                o_busy,
    output logic                o_ovf
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t              r_state, w_next;
    logic [TS_WIDTH-1:0] r_ts, r_snap;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [PW-1:0]       r_ptr, r_win, w_sel, w_idx, w_ptr_inc;
    logic                w_any;
    // Scan downward so the lowest offset from r_ptr with a pending request wins
    always_comb begin
        w_sel = r_ptr;
        w_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
            w_sel = i_req[w_idx] ? w_idx : w_sel;
        end
        w_any     = |i_req;
        w_ptr_inc = (r_win == PW'(NUM_REQ - 1)) ? '0 : r_win + PW'(1);
        w_next    = (r_state == IDLE)  ? (w_any ? GRANT : IDLE) :
                    (r_state == GRANT) ? (i_req[r_win] ? GRANT : RELEASE) : IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_ts    <= '0;
            r_snap  <= '0;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_win   <= '0;
        end else begin
            r_state <= w_next;
            r_ts    <= i_load ? i_load_val : i_tick_10hz ? r_ts + TS_WIDTH'(1) : r_ts;
            if (r_state == IDLE && w_any) begin
                r_snap <= r_ts;
                r_gnt  <= NUM_REQ'(1) << w_sel;
                r_win  <= w_sel;
            end
            if (r_state == GRANT && !i_req[r_win]) r_gnt <= '0;
            if (r_state == RELEASE) r_ptr <= w_ptr_inc;
        end
    end
`ifdef TS_OVERFLOW_FLAG_EN
    logic r_ovf;
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_ovf <= 1'b0;
        else r_ovf <= i_load ? 1'b0 : (i_tick_10hz && &r_ts) ? 1'b1 : r_ovf;
    end
    assign o_ovf = r_ovf;
`else
    assign o_ovf = 1'b0;
`endif
    assign o_timestamp = r_ts;
    assign o_snap      = r_snap;
    assign o_gnt       = r_gnt;
    assign o_busy      = (r_state != IDLE);
endmodule
